// File: rtl/glitch_filter_n.sv
// Multi-channel synchronised glitch filter: a new input level must persist for
// STABLE enabled cycles before y follows it; shorter excursions count as glitches.
module glitch_filter_n #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STABLE      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [CHANNELS-1:0] x,
  output logic [CHANNELS-1:0] y,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                glitch_any,
  output logic [GCNT_W-1:0]   glitch_cnt
);

  localparam int unsigned CW = $clog2(STABLE + 1);
  localparam int unsigned PW = $clog2(CHANNELS + 1);
  localparam int unsigned SW = GCNT_W + PW;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
  localparam logic [SW-1:0] GCNT_MAX = SW'({GCNT_W{1'b1}});

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] y_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] ev;
  logic [PW-1:0]       pop;
  logic [SW-1:0]       sum;
  logic [GCNT_W-1:0]   gcnt_d;
  logic                gany_d;

  // Synchroniser chain, free-running regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= x;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel stability counter: accept after STABLE mismatching cycles,
  // flag a glitch when the level returns before that
  always_comb begin
    y_d    = y;
    rise_d = '0;
    fall_d = '0;
    ev     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (en) begin
        if (s[i] == y[i]) begin
          cnt_d[i] = '0;
          ev[i]    = (cnt_q[i] != '0);
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]  = '0;
          y_d[i]    = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Saturating glitch accounting; clr takes priority over same-cycle events
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) pop = pop + PW'(ev[i]);
    sum    = SW'(glitch_cnt) + SW'(pop);
    gcnt_d = glitch_cnt;
    gany_d = glitch_any;
    if (clr) begin
      gcnt_d = '0;
      gany_d = 1'b0;
    end else if (pop != '0) begin
      gcnt_d = (sum > GCNT_MAX) ? '1 : sum[GCNT_W-1:0];
      gany_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y          <= '0;
      rise       <= '0;
      fall       <= '0;
      glitch_cnt <= '0;
      glitch_any <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      y          <= y_d;
      rise       <= rise_d;
      fall       <= fall_d;
      glitch_cnt <= gcnt_d;
      glitch_any <= gany_d;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_glitch_filter_n.sv
// Bench for glitch_filter_n: table of per-edge expectations fed through a
// scoreboard queue, plus hand-written saturation and async-reset sequences.
module tb_glitch_filter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] x;
  logic [3:0] y, rise, fall;
  logic [7:0] gcnt;
  logic       gany;
  logic [3:0] y_s, rise_s, fall_s;
  logic [1:0] gcnt_s;
  logic       gany_s;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [3:0] x;
    logic       en;
    logic       clr;
    logic [3:0] y;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [7:0] gcnt;
    logic       gany;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  glitch_filter_n dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .y(y), .rise(rise), .fall(fall), .glitch_any(gany), .glitch_cnt(gcnt)
  );

  glitch_filter_n #(.GCNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .y(y_s), .rise(rise_s), .fall(fall_s), .glitch_any(gany_s), .glitch_cnt(gcnt_s)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void rep(input int n, input string name, input int xv, input int e,
                              input int c, input int yv, input int r, input int f,
                              input int g, input int ga);
    vec_t v;
    v.name = name; v.x = 4'(xv); v.en = 1'(e); v.clr = 1'(c);
    v.y = 4'(yv); v.rise = 4'(r); v.fall = 4'(f); v.gcnt = 8'(g); v.gany = 1'(ga);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic compare(input vec_t e);
    n_chk++;
    if (y !== e.y || rise !== e.rise || fall !== e.fall || gcnt !== e.gcnt || gany !== e.gany ||
        y_s !== e.y || rise_s !== e.rise || fall_s !== e.fall || gany_s !== e.gany) begin
      n_fail++;
      $display("FAIL %s: got y=%b rise=%b fall=%b gcnt=%0d gany=%b (narrow: y=%b rise=%b fall=%b gany=%b), expected y=%b rise=%b fall=%b gcnt=%0d gany=%b",
               e.name, y, rise, fall, gcnt, gany, y_s, rise_s, fall_s, gany_s,
               e.y, e.rise, e.fall, e.gcnt, e.gany);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Drive one edge's inputs, queue its expectation, compare after the edge
  task automatic step(input vec_t v);
    vec_t e;
    x = v.x; en = v.en; clr = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      compare(e);
    end
  endtask

  task automatic drive(input logic [3:0] xv);
    x = xv; en = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int rst_idx;

  initial begin
    // clean rise then fall on channel 0
    rep(5, "rise0_wait", 1, 1, 0, 0, 0, 0, 0, 0);
    rep(1, "rise0_edge6", 1, 1, 0, 1, 1, 0, 0, 0);
    rep(1, "rise0_after", 1, 1, 0, 1, 0, 0, 0, 0);
    rep(5, "fall0_wait", 0, 1, 0, 1, 0, 0, 0, 0);
    rep(1, "fall0_edge6", 0, 1, 0, 0, 0, 1, 0, 0);
    rep(1, "fall0_after", 0, 1, 0, 0, 0, 0, 0, 0);
    // 3-cycle pulse on channel 1 is rejected
    rep(3, "short1_high", 2, 1, 0, 0, 0, 0, 0, 0);
    rep(2, "short1_low", 0, 1, 0, 0, 0, 0, 0, 0);
    rep(1, "short1_reject", 0, 1, 0, 0, 0, 0, 1, 1);
    rep(2, "short1_post", 0, 1, 0, 0, 0, 0, 1, 1);
    // 4-cycle pulse on channel 1 is accepted, then the return to 0 too
    rep(4, "long1_high", 2, 1, 0, 0, 0, 0, 1, 1);
    rep(1, "long1_low", 0, 1, 0, 0, 0, 0, 1, 1);
    rep(1, "long1_accept", 0, 1, 0, 2, 2, 0, 1, 1);
    rep(3, "long1_hold", 0, 1, 0, 2, 0, 0, 1, 1);
    rep(1, "long1_fall", 0, 1, 0, 0, 0, 2, 1, 1);
    rep(1, "long1_post", 0, 1, 0, 0, 0, 0, 1, 1);
    // three simultaneous 2-cycle glitches
    rep(2, "multi_high", 13, 1, 0, 0, 0, 0, 1, 1);
    rep(2, "multi_low", 0, 1, 0, 0, 0, 0, 1, 1);
    rep(1, "multi_glitch", 0, 1, 0, 0, 0, 0, 4, 1);
    rep(1, "multi_post", 0, 1, 0, 0, 0, 0, 4, 1);
    // enable freeze on channel 2 after cnt reaches 2
    rep(4, "frz_count", 4, 1, 0, 0, 0, 0, 4, 1);
    rep(10, "frz_hold", 4, 0, 0, 0, 0, 0, 4, 1);
    rep(1, "frz_resume", 4, 1, 0, 0, 0, 0, 4, 1);
    rep(1, "frz_accept", 4, 1, 0, 4, 4, 0, 4, 1);
    rep(1, "frz_post", 4, 1, 0, 4, 0, 0, 4, 1);
    // clr coinciding with a glitch on channel 0
    rep(2, "clr_high", 5, 1, 0, 4, 0, 0, 4, 1);
    rep(2, "clr_low", 4, 1, 0, 4, 0, 0, 4, 1);
    rep(1, "clr_wins", 4, 1, 1, 4, 0, 0, 0, 0);
    rep(1, "clr_post", 4, 1, 0, 4, 0, 0, 0, 0);
    rst_idx = vecs.size();
    // all-ones step after an async reset
    rep(5, "rst_wait", 15, 1, 0, 0, 0, 0, 0, 0);
    rep(1, "rst_edge6", 15, 1, 0, 15, 15, 0, 0, 0);
    rep(1, "rst_after", 15, 1, 0, 15, 0, 0, 0, 0);

    rst = 1'b1; en = 1'b1; clr = 1'b0; x = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_rise", 32'(rise), 32'h0);
    chk("reset_fall", 32'(fall), 32'h0);
    chk("reset_gcnt", 32'(gcnt), 32'h0);
    chk("reset_gany", 32'(gany), 32'h0);
    #2 rst = 1'b0;

    for (int i = 0; i < rst_idx; i++) step(vecs[i]);

    // GCNT_W=2 instance saturates at 3, wide instance keeps counting
    for (int k = 1; k <= 5; k++) begin
      drive(4'b1100);
      drive(4'b1100);
      drive(4'b0100);
      drive(4'b0100);
      chk($sformatf("sat_before_%0d", k), 32'(gcnt_s), 32'((k - 1 > 3) ? 3 : k - 1));
      drive(4'b0100);
      chk($sformatf("sat_narrow_%0d", k), 32'(gcnt_s), 32'((k > 3) ? 3 : k));
      chk($sformatf("sat_wide_%0d", k), 32'(gcnt), 32'(k));
      drive(4'b0100);
    end

    // async reset mid-count with x all ones
    drive(4'b1111);
    drive(4'b1111);
    drive(4'b1111);
    chk("prerst_y", 32'(y), 32'h4);
    chk("prerst_gcnt", 32'(gcnt), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y", 32'(y), 32'h0);
    chk("async_rst_rise", 32'(rise), 32'h0);
    chk("async_rst_fall", 32'(fall), 32'h0);
    chk("async_rst_gcnt", 32'(gcnt), 32'h0);
    chk("async_rst_gany", 32'(gany), 32'h0);
    chk("async_rst_gcnt_s", 32'(gcnt_s), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    for (int i = rst_idx; i < vecs.size(); i++) step(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_filter_n.md
Name: glitch_filter_n

Overview:
- Clocked, parametrised multi-channel glitch and hazard filter; the synchronous successor of the latch-based hazard filter.
- Each input is synchronised, then must hold a new level for STABLE consecutive cycles before the filtered output follows it.
- Shorter excursions are rejected and counted as glitches.
- Also emits per-channel edge pulses; sits between raw combinational or asynchronous signals and downstream logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- STABLE, 4, consecutive stable cycles required to accept a level change (>=1).
- SYNC_STAGES, 2, synchroniser flip-flop depth per channel (>=2).
- GCNT_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  filter enable; when low, filter state is frozen.
- clr  input  1  synchronous clear of glitch_cnt and glitch_any.
- x  input  CHANNELS  raw inputs, may be asynchronous.
- y  output  CHANNELS  filtered levels.
- rise  output  CHANNELS  one-cycle pulse when y[i] goes 0->1.
- fall  output  CHANNELS  one-cycle pulse when y[i] goes 1->0.
- glitch_any  output  1  sticky flag: at least one glitch rejected since reset or clr.
- glitch_cnt  output  GCNT_W  saturating count of rejected glitches.

Behaviour:
- Reset (async, rst=1):
  - All synchroniser stages = 0; y = 0; rise = fall = 0.
  - Per-channel counters = 0; glitch_cnt = 0; glitch_any = 0.
  - rst released mid-count: everything restarts from 0; no pulse is generated on release.
- Synchroniser: x[i] passes through SYNC_STAGES flops, always clocked, independent of en. s[i] is the last stage.
- Per-channel counter cnt[i], width clog2(STABLE+1). On each edge with en=1:
  - s==y and cnt==0: hold.
  - s==y and cnt!=0: cnt<=0, and a glitch event fires for channel i (excursion shorter than STABLE).
  - s!=y and cnt<STABLE-1: cnt<=cnt+1.
  - s!=y and cnt==STABLE-1: y<=s, cnt<=0, and rise[i] or fall[i] is high for exactly the next cycle.
- Latency: a clean step on x that is captured by the first synchroniser flop at edge 1 reaches y at edge SYNC_STAGES+STABLE (defaults: edge 6).
- STABLE=1: y follows s one edge after s changes. Glitch events are impossible.
- rise/fall are registered; they are 0 in every cycle with no acceptance. Both can never be high together on one channel.
- en=0:
  - cnt, y and the glitch logic hold.
  - rise, fall = 0; no glitch events.
  - The synchroniser keeps sampling.
  - On en rising, evaluation resumes with the held cnt.
- Glitch accounting:
  - Glitch events per cycle = popcount of per-channel events (0..CHANNELS).
  - glitch_cnt <= min(glitch_cnt + popcount, 2^GCNT_W-1). Saturates and never wraps.
  - glitch_any <= 1 on any event.
  - clr=1: glitch_cnt <= 0, glitch_any <= 0. Events in the same cycle are discarded (clr wins).
- Channels are fully independent. Simultaneous acceptances or glitches on several channels are all handled in the same cycle.

Test Plan:
- Reset check: assert rst mid-operation with x=all 1s and cnt nonzero -> y, rise, fall, glitch_cnt and glitch_any are 0 immediately, without waiting for a clock. After release with x held at 1111, y=1111 at edge 6 and rise=1111 for one cycle.
- Clean step: defaults, x[0] 0->1 held -> y[0]=1 after edge 6 exactly, rise[0] high one cycle, glitch_cnt stays 0. Then x[0] 1->0 -> fall[0] high one cycle, 6 edges later.
- Short pulse: x[1] high for 3 cycles (STABLE-1) -> y[1] stays 0, no rise, glitch_cnt=1, glitch_any=1. A 4-cycle pulse on the same channel -> accepted, and glitch_cnt is unchanged.
- Concurrent glitches: 2-cycle pulses on x[0], x[2] and x[3] in the same cycle -> glitch_cnt increments by 3 in one edge. A clr pulse coinciding with a fourth glitch -> glitch_cnt=0, glitch_any=0.
- Saturation: GCNT_W=2, five isolated glitches -> glitch_cnt sequence 1,2,3,3,3.
- Enable freeze: drop en after cnt reaches 2 while x stays changed -> y, cnt and rise are frozen for 10 cycles. Re-raise en -> y updates 2 edges later, with cnt continuing from 2 to STABLE-1.
